// File: rtl/lattice_seq.sv
// Sample-rate sequencer for a cascade of NSECT second-order all-pole sections.
// Time-shares one external multiplier; holds coefficients and per-section delay state.
module lattice_seq #(
  parameter int NSECT  = 6,
  parameter int DATA_W = 16,
  parameter int COEF_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     coef_wr,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     clr,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic signed [DATA_W-1:0] mul_sig,
  output logic signed [COEF_W-1:0] mul_coef,
  output logic                     mul_start,
  input  logic                     mul_done,
  input  logic signed [DATA_W-1:0] mul_result
);

  localparam int NCOEF = 2 * NSECT;
  localparam int SEC_W = (NSECT > 1) ? $clog2(NSECT) : 1;
  localparam int CA_W  = SEC_W + 1;
  localparam int ACC_W = DATA_W + 2;

  localparam logic [SEC_W-1:0] LAST_SECT = SEC_W'(NSECT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_UPD   = 2'd3;

  logic [1:0]               state;
  logic [SEC_W-1:0]         sect;
  logic                     tap;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] y;
  logic signed [DATA_W-1:0] d1 [NSECT];
  logic signed [DATA_W-1:0] d2 [NSECT];
  logic signed [COEF_W-1:0] coef [NCOEF];

  function automatic logic signed [DATA_W-1:0] sat_acc(input logic signed [ACC_W-1:0] a);
    if (a > ACC_MAX)      return ACC_MAX[DATA_W-1:0];
    else if (a < ACC_MIN) return ACC_MIN[DATA_W-1:0];
    else                  return a[DATA_W-1:0];
  endfunction

  assign y    = sat_acc(acc);
  assign busy = (state != S_IDLE);

  // Multiplier request decoded purely from registered state; zero outside ISSUE.
  always_comb begin
    mul_start = (state == S_ISSUE);
    mul_sig   = '0;
    mul_coef  = '0;
    if (mul_start) begin
      mul_sig  = tap ? d2[sect] : d1[sect];
      mul_coef = coef[{sect, tap}];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
    end else if (coef_wr && (int'(coef_addr) < NCOEF)) begin
      coef[coef_addr[CA_W-1:0]] <= coef_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSECT; i++) begin
        d1[i] <= '0;
        d2[i] <= '0;
      end
    end else if ((state == S_IDLE) && clr) begin
      for (int i = 0; i < NSECT; i++) begin
        d1[i] <= '0;
        d2[i] <= '0;
      end
    end else if (state == S_UPD) begin
      d2[sect] <= d1[sect];
      d1[sect] <= y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sect       <= '0;
      tap        <= 1'b0;
      acc        <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample_valid && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            acc   <= ACC_W'(sample_in);
            sect  <= '0;
            tap   <= 1'b0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (mul_done) begin
            acc <= acc + ACC_W'(mul_result);
            if (!tap) begin
              tap   <= 1'b1;
              state <= S_ISSUE;
            end else begin
              state <= S_UPD;
            end
          end
        end
        S_UPD: begin
          // Saturated section output feeds the next section as its input.
          acc <= ACC_W'(y);
          tap <= 1'b0;
          if (sect == LAST_SECT) begin
            sample_out <= y;
            out_valid  <= 1'b1;
            state      <= S_IDLE;
          end else begin
            sect  <= sect + SEC_W'(1);
            state <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
